// File: rtl/div_pkg.sv
// Shared constants for the restoring divider: state encoding and default widths.
// No logic here; latency and flow control belong to div_frame.
// Imported by div_step and div_frame.
package div_pkg;

  localparam int A_W   = 8;
  localparam int B_W   = 4;
  localparam int CNT_W = 3;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = S_IDLE,
    RUN  = S_RUN,
    DONE = S_DONE
  } state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in the next dividend bit, compare, subtract.
// Latency: purely combinational.
// No flow control; the caller decides when the result is registered.
module div_step
  import div_pkg::*;
#(
  parameter int B_W_P = B_W
) (
  input  logic [B_W_P:0]   r_in,
  input  logic             q_msb,
  input  logic [B_W_P-1:0] d,
  output logic [B_W_P:0]   r_out,
  output logic             q_bit
);

  // The partial remainder is always below the divisor, so its top bit is zero;
  // the wide trial value keeps every bit in the compare without changing the result.
  logic [B_W_P+1:0] t_wide;
  logic [B_W_P+1:0] d_wide;

  // Compare the shifted partial remainder against the divisor and restore on borrow
  always_comb begin
    t_wide = {r_in, q_msb};
    d_wide = {2'b00, d};
    r_out  = (B_W_P+1)'(t_wide);
    q_bit  = 1'b0;
    if (t_wide >= d_wide) begin
      r_out = (B_W_P+1)'(t_wide - d_wide);
      q_bit = 1'b1;
    end
  end

endmodule

// File: rtl/div_frame.sv
// Sequential 8/4 unsigned restoring divider, one quotient bit per clock, start/done handshake.
// Latency: done 9 cycles after an accepted start (1 cycle when the divisor is zero).
// start is only honoured in IDLE; results hold until the next accepted start, no output stall.
module div_frame
  import div_pkg::*;
#(
  parameter int A_W_P   = A_W,
  parameter int B_W_P   = B_W,
  parameter int CNT_W_P = CNT_W
) (
  input  logic               Clk,
  input  logic               reset,
  input  logic               start,
  input  logic [A_W_P-1:0]   dividend,
  input  logic [B_W_P-1:0]   divisor,
  output logic               busy,
  output logic               done,
  output logic               div_zero,
  output logic [A_W_P-1:0]   quotient,
  output logic [B_W_P-1:0]   remainder
);

  state_t               state, state_nxt;
  logic [B_W_P:0]       r;
  logic [A_W_P-1:0]     q;
  logic [B_W_P-1:0]     d;
  logic [CNT_W_P-1:0]   cnt;
  logic [B_W_P:0]       r_nxt;
  logic                 q_bit;
  logic                 last_step;

  assign last_step = (cnt == CNT_W_P'(A_W_P - 1));

  div_step #(.B_W_P(B_W_P)) u_step (
    .r_in  (r),
    .q_msb (q[A_W_P-1]),
    .d     (d),
    .r_out (r_nxt),
    .q_bit (q_bit)
  );

  // State register
  always_ff @(posedge Clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic: a zero divisor skips iteration and reports straight away
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) state_nxt = (divisor == '0) ? DONE : RUN;
      end
      RUN: begin
        if (last_step) state_nxt = DONE;
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Status flags are registered from the next state so they align with the state register
  always_ff @(posedge Clk) begin
    if (reset) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= (state_nxt == RUN);
      done <= (state_nxt == DONE);
    end
  end

  // Datapath: operand capture, shift-subtract iteration and result hold
  always_ff @(posedge Clk) begin
    if (reset) begin
      r         <= '0;
      q         <= '0;
      d         <= '0;
      cnt       <= '0;
      div_zero  <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (divisor == '0) begin
              div_zero  <= 1'b1;
              quotient  <= '1;
              remainder <= '0;
            end else begin
              q        <= dividend;
              r        <= '0;
              d        <= divisor;
              cnt      <= '0;
              div_zero <= 1'b0;
            end
          end
        end
        RUN: begin
          q   <= {q[A_W_P-2:0], q_bit};
          r   <= r_nxt;
          cnt <= cnt + CNT_W_P'(1);
          if (last_step) begin
            quotient  <= {q[A_W_P-2:0], q_bit};
            remainder <= r_nxt[B_W_P-1:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_frame.sv
// Directed bench for div_frame: results, handshake timing, zero divisor, ignored start, reset.
// Inputs change and outputs are sampled on the falling edge.
// Every wait on done is bounded by a cycle budget.
module tb_div_frame;

  logic       Clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] dividend;
  logic [3:0] divisor;
  logic       busy;
  logic       done;
  logic       div_zero;
  logic [7:0] quotient;
  logic [3:0] remainder;

  int total = 0;
  int bad   = 0;

  div_frame dut (
    .Clk       (Clk),
    .reset     (reset),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .div_zero  (div_zero),
    .quotient  (quotient),
    .remainder (remainder)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic start_op(input logic [7:0] a, input logic [3:0] b);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    @(negedge Clk);
    start = 1'b0;
  endtask

  // Start an operation, wait for done, check latency, busy length, results and single-cycle done
  task automatic do_op(input string tag, input logic [7:0] a, input logic [3:0] b,
                       input int exp_q, input int exp_r, input int exp_dz,
                       input int exp_lat, input int exp_busy);
    int lat;
    int bcnt;
    start_op(a, b);
    lat  = 1;
    bcnt = 0;
    while (!done && lat < 20) begin
      if (busy) bcnt++;
      @(negedge Clk);
      lat++;
    end
    chk({tag, "_latency"}, lat, exp_lat);
    chk({tag, "_busy_cycles"}, bcnt, exp_busy);
    chk({tag, "_quotient"}, quotient, exp_q);
    chk({tag, "_remainder"}, remainder, exp_r);
    chk({tag, "_div_zero"}, div_zero, exp_dz);
    chk({tag, "_busy_at_done"}, busy, 0);
    @(negedge Clk);
    chk({tag, "_done_drops"}, done, 0);
  endtask

  initial begin
    int dones;
    logic [7:0] q_seen;
    logic [3:0] r_seen;

    reset    = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    @(negedge Clk);
    @(negedge Clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_div_zero", div_zero, 0);
    chk("rst_quotient", quotient, 0);
    chk("rst_remainder", remainder, 0);
    reset = 1'b0;
    @(negedge Clk);

    do_op("200_7", 8'd200, 4'd7, 28, 4, 0, 9, 8);
    do_op("255_15", 8'd255, 4'd15, 17, 0, 0, 9, 8);
    do_op("5_9", 8'd5, 4'd9, 0, 5, 0, 9, 8);
    do_op("0_3", 8'd0, 4'd3, 0, 0, 0, 9, 8);

    do_op("77_0", 8'd77, 4'd0, 255, 0, 1, 1, 0);
    do_op("12_5", 8'd12, 4'd5, 2, 2, 0, 9, 8);

    // A second start three cycles into RUN, with new operands, must be ignored
    start_op(8'd200, 4'd7);
    @(negedge Clk);
    @(negedge Clk);
    start    = 1'b1;
    dividend = 8'd9;
    divisor  = 4'd3;
    @(negedge Clk);
    start    = 1'b0;
    dividend = 8'd1;
    divisor  = 4'd1;
    dones  = 0;
    q_seen = '0;
    r_seen = '0;
    for (int i = 0; i < 16; i++) begin
      if (done) begin
        dones++;
        q_seen = quotient;
        r_seen = remainder;
      end
      @(negedge Clk);
    end
    chk("ignore_done_count", dones, 1);
    chk("ignore_quotient", q_seen, 28);
    chk("ignore_remainder", r_seen, 4);

    // Reset during RUN clears everything and suppresses done
    start_op(8'd100, 4'd3);
    @(negedge Clk);
    @(negedge Clk);
    reset = 1'b1;
    @(negedge Clk);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_div_zero", div_zero, 0);
    chk("midrst_quotient", quotient, 0);
    chk("midrst_remainder", remainder, 0);
    reset = 1'b0;
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      if (done) dones++;
      @(negedge Clk);
    end
    chk("midrst_no_done", dones, 0);
    do_op("100_3", 8'd100, 4'd3, 33, 1, 0, 9, 8);

    // Back-to-back: do_op returns on the first IDLE cycle, so the next start hits E10
    do_op("50_6", 8'd50, 4'd6, 8, 2, 0, 9, 8);
    chk("b2b_hold_quotient", quotient, 8);
    chk("b2b_hold_remainder", remainder, 2);
    do_op("99_10", 8'd99, 4'd10, 9, 9, 0, 9, 8);
    for (int i = 0; i < 3; i++) @(negedge Clk);
    chk("hold_quotient", quotient, 9);
    chk("hold_remainder", remainder, 9);
    chk("hold_busy", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
